// File: rtl/cpu_io_route_pkg.sv
// Shared definitions for the CPU-IO route matrix: config FSM encoding and select sizing.
package cpu_io_route_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERR    = 2'd3
    } state_t;

    localparam int DEFAULT_N_IN = 16;

    // One extra encoding beyond the inputs is needed for the GND select.
    function automatic int sel_width(input int n_in);
        return $clog2(n_in + 1);
    endfunction

    function automatic int gnd_sel(input int n_in);
        return n_in;
    endfunction

endpackage

// File: rtl/cpu_io_route_cell.sv
// One routed output: shadow/active select pair, N_IN:1 mux with GND default, optional output flop.
module cpu_io_route_cell
    import cpu_io_route_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int PIPE  = 1,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IN-1:0]  in_bus,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_data,
    input  logic             commit,
    output logic             route_out
);

    localparam logic [SEL_W-1:0] GND_SEL = SEL_W'(gnd_sel(N_IN));

    logic [SEL_W-1:0] shadow_sel;
    logic [SEL_W-1:0] active_sel;
    logic             mux_p0;

    // Shadow holds pending data only; a stream is never committed unless fully reloaded.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            shadow_sel <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_sel <= GND_SEL;
        end else if (commit) begin
            active_sel <= shadow_sel;
        end
    end

    // Any select not matching a real input, including unused encodings, routes GND.
    always_comb begin
        mux_p0 = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (active_sel == SEL_W'(i)) begin
                mux_p0 = in_bus[i];
            end
        end
    end

    // ---- stage p0 -> p1 ----
    generate
        if (PIPE != 0) begin : g_pipe
            logic out_p1;
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_p1 <= 1'b0;
                end else begin
                    out_p1 <= mux_p0;
                end
            end
            assign route_out = out_p1;
        end else begin : g_comb
            assign route_out = mux_p0;
        end
    endgenerate

endmodule

// File: rtl/cpu_io_route_matrix.sv
// Runtime-configurable CPU-IO switch matrix: streamed shadow load, atomic commit to N_OUT route cells.
module cpu_io_route_matrix
    import cpu_io_route_pkg::*;
#(
    parameter  int N_IN  = 16,
    parameter  int N_OUT = 12,
    parameter  int PIPE  = 1,
    localparam int SEL_W = sel_width(N_IN)
) (
    input  logic             UserCLK,
    input  logic             RST,
    input  logic [N_IN-1:0]  in_bus,
    output logic [N_OUT-1:0] out_bus,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEL_W-1:0] cfg_data,
    input  logic             cfg_last,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int             IDX_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] cfg_idx;
    logic             accept;
    logic             at_last;
    logic             commit;
    logic [N_OUT-1:0] wr_en;

    assign accept  = cfg_valid & cfg_ready;
    assign at_last = (cfg_idx == LAST_IDX);

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Framing: cfg_last must coincide exactly with the final output index.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    if (at_last) begin
                        state_next = cfg_last ? ST_COMMIT : ST_ERR;
                    end else begin
                        state_next = cfg_last ? ST_ERR : ST_LOAD;
                    end
                end
            end
            ST_COMMIT: state_next = ST_IDLE;
            ST_ERR:    state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state == ST_IDLE) || (state == ST_LOAD);
        cfg_done  = (state == ST_COMMIT);
        cfg_err   = (state == ST_ERR);
        commit    = (state == ST_COMMIT);
    end

    always_ff @(posedge UserCLK) begin
        if (RST) begin
            cfg_idx <= '0;
        end else if ((state == ST_COMMIT) || (state == ST_ERR)) begin
            cfg_idx <= '0;
        end else if (accept) begin
            cfg_idx <= at_last ? '0 : cfg_idx + 1'b1;
        end
    end

    always_comb begin
        wr_en = '0;
        for (int j = 0; j < N_OUT; j++) begin
            wr_en[j] = accept && (cfg_idx == IDX_W'(j));
        end
    end

    generate
        for (genvar j = 0; j < N_OUT; j++) begin : g_cell
            cpu_io_route_cell #(
                .N_IN  (N_IN),
                .PIPE  (PIPE),
                .SEL_W (SEL_W)
            ) u_cell (
                .clk       (UserCLK),
                .rst       (RST),
                .in_bus    (in_bus),
                .wr_en     (wr_en[j]),
                .wr_data   (cfg_data),
                .commit    (commit),
                .route_out (out_bus[j])
            );
        end
    endgenerate

endmodule

// File: tb/tb_cpu_io_route_matrix.sv
// Directed bench: default 16x12 registered matrix plus a 4x1 combinational instance.
module tb_cpu_io_route_matrix;

    logic        UserCLK = 1'b0;
    logic        RST;
    logic [15:0] in_bus;
    logic [11:0] out_bus;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [4:0]  cfg_data;
    logic        cfg_last;
    logic        cfg_done;
    logic        cfg_err;

    logic [3:0]  b_in;
    logic [0:0]  b_out;
    logic        b_valid;
    logic        b_ready;
    logic [2:0]  b_data;
    logic        b_last;
    logic        b_done;
    logic        b_err;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    cpu_io_route_matrix #(.N_IN(16), .N_OUT(12), .PIPE(1)) dut (
        .UserCLK   (UserCLK),
        .RST       (RST),
        .in_bus    (in_bus),
        .out_bus   (out_bus),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    cpu_io_route_matrix #(.N_IN(4), .N_OUT(1), .PIPE(0)) dut_b (
        .UserCLK   (UserCLK),
        .RST       (RST),
        .in_bus    (b_in),
        .out_bus   (b_out),
        .cfg_valid (b_valid),
        .cfg_ready (b_ready),
        .cfg_data  (b_data),
        .cfg_last  (b_last),
        .cfg_done  (b_done),
        .cfg_err   (b_err)
    );

    always #5 UserCLK = ~UserCLK;

    always @(negedge UserCLK) begin
        if (cfg_done) done_cnt <= done_cnt + 1;
        if (cfg_err)  err_cnt  <= err_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] route_off(input int off, input logic [15:0] v);
        logic [11:0] r;
        r = '0;
        for (int j = 0; j < 12; j++) r[j] = v[j + off];
        return r;
    endfunction

    task automatic send_a(input logic [4:0] d, input logic last);
        int n;
        @(posedge UserCLK); #1;
        cfg_valid = 1'b1;
        cfg_data  = d;
        cfg_last  = last;
        n = 0;
        @(negedge UserCLK);
        while (!cfg_ready && n < 8) begin
            @(negedge UserCLK);
            n++;
        end
        if (!cfg_ready) check("a_ready_timeout", 32'(cfg_ready), 32'h1);
        @(posedge UserCLK); #1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] d, input logic last);
        int n;
        @(posedge UserCLK); #1;
        b_valid = 1'b1;
        b_data  = d;
        b_last  = last;
        n = 0;
        @(negedge UserCLK);
        while (!b_ready && n < 8) begin
            @(negedge UserCLK);
            n++;
        end
        if (!b_ready) check("b_ready_timeout", 32'(b_ready), 32'h1);
        @(posedge UserCLK); #1;
        b_valid = 1'b0;
        b_last  = 1'b0;
    endtask

    task automatic apply(input logic [15:0] v);
        @(posedge UserCLK); #1;
        in_bus = v;
        @(posedge UserCLK); #1;
        @(negedge UserCLK);
    endtask

    initial begin
        logic [15:0] prev_in;
        logic [11:0] exp_out;

        RST = 1'b1;
        in_bus = '0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0;
        b_in = '0; b_valid = 1'b0; b_data = '0; b_last = 1'b0;
        repeat (3) @(posedge UserCLK);
        #1;
        RST = 1'b0;

        // reset state
        in_bus = 16'hFFFF;
        @(negedge UserCLK);
        check("rst_out_ffff", 32'(out_bus), 32'h0);
        check("rst_ready", 32'(cfg_ready), 32'h1);
        apply(16'hA5A5);
        check("rst_out_a5a5", 32'(out_bus), 32'h0);
        check("rst_no_done", 32'(done_cnt), 32'h0);
        check("rst_no_err", 32'(err_cnt), 32'h0);

        // reversed mapping j -> 11-j
        @(posedge UserCLK); #1;
        in_bus = 16'h0001;
        for (int j = 0; j < 12; j++) send_a(5'(11 - j), j == 11);
        @(negedge UserCLK);
        check("rev_done_pulse", 32'(cfg_done), 32'h1);
        check("rev_bubble", 32'(cfg_ready), 32'h0);
        check("rev_old_in_commit", 32'(out_bus), 32'h0);
        @(posedge UserCLK); #1;
        @(negedge UserCLK);
        check("rev_old_after_commit", 32'(out_bus), 32'h0);
        check("rev_done_low", 32'(cfg_done), 32'h0);
        @(posedge UserCLK); #1;
        @(negedge UserCLK);
        check("rev_new_0001", 32'(out_bus), 32'h800);
        check("rev_done_once", 32'(done_cnt), 32'h1);
        @(posedge UserCLK); #1;
        in_bus = 16'h0800;
        @(negedge UserCLK);
        check("pipe_latency_hold", 32'(out_bus), 32'h800);
        @(posedge UserCLK); #1;
        @(negedge UserCLK);
        check("rev_new_0800", 32'(out_bus), 32'h001);
        apply(16'h0FFF);
        check("rev_new_0fff", 32'(out_bus), 32'hFFF);
        apply(16'hF000);
        check("rev_new_f000", 32'(out_bus), 32'h000);

        // early cfg_last -> error, routing untouched
        for (int j = 0; j < 6; j++) send_a(5'(j), j == 5);
        @(negedge UserCLK);
        check("early_last_err", 32'(cfg_err), 32'h1);
        check("early_last_bubble", 32'(cfg_ready), 32'h0);
        apply(16'h0001);
        check("early_last_keep", 32'(out_bus), 32'h800);
        check("early_last_errcnt", 32'(err_cnt), 32'h1);
        check("early_last_nodone", 32'(done_cnt), 32'h1);
        for (int j = 0; j < 12; j++) send_a(5'(j), j == 11);
        apply(16'h0ABC);
        check("ident_0abc", 32'(out_bus), 32'hABC);
        check("ident_donecnt", 32'(done_cnt), 32'h2);

        // missing cfg_last on final index -> error
        for (int j = 0; j < 12; j++) send_a(5'd16, 1'b0);
        @(negedge UserCLK);
        check("no_last_err", 32'(cfg_err), 32'h1);
        apply(16'h0555);
        check("no_last_keep", 32'(out_bus), 32'h555);
        check("no_last_errcnt", 32'(err_cnt), 32'h2);

        // slow load (1-in-3) while inputs toggle; old identity map holds until commit
        @(posedge UserCLK); #1;
        prev_in = in_bus;
        for (int k = 0; k < 42; k++) begin
            in_bus = 16'h5A5A ^ (16'(k) * 16'h0F1D);
            if ((k % 3 == 0) && (k / 3 < 12)) begin
                cfg_valid = 1'b1;
                cfg_data  = 5'(k / 3 + 4);
                cfg_last  = (k / 3 == 11);
            end else begin
                cfg_valid = 1'b0;
                cfg_last  = 1'b0;
            end
            @(negedge UserCLK);
            exp_out = route_off((k >= 36) ? 4 : 0, prev_in);
            check($sformatf("slow_load_k%0d", k), 32'(out_bus), 32'(exp_out));
            if (k == 34) check("slow_load_done", 32'(cfg_done), 32'h1);
            prev_in = in_bus;
            @(posedge UserCLK); #1;
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;

        // reset in the middle of a stream
        for (int j = 0; j < 7; j++) send_a(5'(j), 1'b0);
        RST = 1'b1;
        in_bus = 16'hFFFF;
        @(posedge UserCLK); #1;
        RST = 1'b0;
        @(negedge UserCLK);
        check("midrst_out", 32'(out_bus), 32'h0);
        check("midrst_ready", 32'(cfg_ready), 32'h1);
        check("midrst_nodone", 32'(cfg_done), 32'h0);
        for (int j = 0; j < 12; j++) send_a((j < 5) ? 5'(j + 7) : 5'd16, j == 11);
        apply(16'h0F80);
        check("restart_0f80", 32'(out_bus), 32'h01F);
        apply(16'h0080);
        check("restart_0080", 32'(out_bus), 32'h001);
        check("restart_donecnt", 32'(done_cnt), 32'h4);

        // unused encodings 16..31 route GND
        for (int j = 0; j < 12; j++) send_a((j % 2 == 0) ? 5'(j) : 5'(20 + j), j == 11);
        apply(16'hFFFF);
        check("hisel_ffff", 32'(out_bus), 32'h555);
        apply(16'h0AAA);
        check("hisel_0aaa", 32'(out_bus), 32'h000);
        apply(16'h0555);
        check("hisel_0555", 32'(out_bus), 32'h555);

        // 4x1 combinational instance
        @(posedge UserCLK); #1;
        b_in = 4'hF;
        @(negedge UserCLK);
        check("b_rst_out", 32'(b_out), 32'h0);
        check("b_rst_ready", 32'(b_ready), 32'h1);
        send_b(3'd2, 1'b1);
        b_in = 4'b0100;
        @(negedge UserCLK);
        check("b_single_done", 32'(b_done), 32'h1);
        check("b_old_in_commit", 32'(b_out), 32'h0);
        @(posedge UserCLK); #1;
        @(negedge UserCLK);
        check("b_new_sel2", 32'(b_out), 32'h1);
        check("b_done_low", 32'(b_done), 32'h0);
        @(posedge UserCLK); #1;
        b_in = 4'b1011;
        @(negedge UserCLK);
        check("b_comb_same_cycle", 32'(b_out), 32'h0);
        send_b(3'd1, 1'b0);
        @(negedge UserCLK);
        check("b_no_last_err", 32'(b_err), 32'h1);
        @(posedge UserCLK); #1;
        b_in = 4'b0100;
        @(negedge UserCLK);
        check("b_err_keep", 32'(b_out), 32'h1);
        send_b(3'd5, 1'b1);
        @(posedge UserCLK); #1;
        b_in = 4'hF;
        @(negedge UserCLK);
        check("b_sel5_gnd", 32'(b_out), 32'h0);
        send_b(3'd3, 1'b1);
        @(posedge UserCLK); #1;
        b_in = 4'b1000;
        @(negedge UserCLK);
        check("b_sel3", 32'(b_out), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
